// File: rtl/tanh_act_scheduler.sv
// Round-robin front end for one shared combinational activation unit: grants one
// requester operand per cycle into an operand stage, captures the unit result into a tagged response stage.
module tanh_act_scheduler #(
  parameter int N_REQ = 4,
  parameter int DW    = 4,
  parameter int IDW   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [DW-1:0]       act_in,
  input  logic [DW-1:0]       act_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_data,
  output logic [IDW-1:0]      rsp_id,
  output logic                busy
);

  logic           op_valid_q, op_valid_d;
  logic [DW-1:0]  op_data_q, op_data_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic           s2_load;
  logic           s1_free;
  logic           grant;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW-1:0] cand_idx;
  logic [DW-1:0]  req_word [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_word[gi]  = req_data[gi*DW +: DW];
      assign req_ready[gi] = grant && (grant_idx == IDW'(gi));
    end
  endgenerate

  assign s2_load = op_valid_q & (~rsp_valid_q | rsp_ready);
  assign s1_free = ~op_valid_q | s2_load;

  // Rotating priority: search starts just after the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign grant = s1_free & grant_found;

  always_comb begin
    op_valid_d  = op_valid_q;
    op_data_d   = op_data_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    ptr_d       = ptr_q;

    if (s2_load) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = act_out;
      rsp_id_d    = op_id_q;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    if (grant) begin
      op_valid_d = 1'b1;
      op_data_d  = req_word[grant_idx];
      op_id_d    = grant_idx;
      ptr_d      = grant_idx;
    end else if (s2_load) begin
      op_valid_d = 1'b0;
    end
  end

  // Reset leaves requester 0 with first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_q  <= 1'b0;
      op_data_q   <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      ptr_q       <= IDW'(N_REQ - 1);
    end else begin
      op_valid_q  <= op_valid_d;
      op_data_q   <= op_data_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign act_in    = op_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = op_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_tanh_act_scheduler.sv
// Directed bench for tanh_act_scheduler; the shared unit is modelled as bitwise inversion.
module tb_tanh_act_scheduler;
  localparam int N_REQ = 4;
  localparam int DW    = 4;
  localparam int IDW   = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N_REQ-1:0]    req_valid = '0;
  logic [N_REQ*DW-1:0] req_data = '0;
  logic [N_REQ-1:0]    req_ready;
  logic [DW-1:0]       act_in;
  logic [DW-1:0]       act_out;
  logic                rsp_valid;
  logic                rsp_ready = 1'b1;
  logic [DW-1:0]       rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic                busy;

  int n_cmp = 0;
  int n_err = 0;

  tanh_act_scheduler #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .act_in(act_in), .act_out(act_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
  );

  assign act_out = ~act_in;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int idx, input logic [DW-1:0] v);
    req_data[idx*DW +: DW] = v;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    next_cycle();
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_act_in", 32'(act_in), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    $display("reset state checked");

    // Single request from requester 2
    rsp_ready = 1'b1;
    set_word(2, 4'h5);
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    next_cycle();
    req_valid = '0;
    #1;
    check("single_c1_act_in", 32'(act_in), 32'h5);
    check("single_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    next_cycle();
    #1;
    check("single_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("single_c2_rsp_data", 32'(rsp_data), 32'hA);
    check("single_c2_rsp_id", 32'(rsp_id), 32'd2);
    next_cycle();
    #1;
    check("single_c3_busy", 32'(busy), 32'd0);
    $display("single request: data=%0h id=%0d", 4'hA, 2);

    // All-request fairness, eight accepts
    do_reset();
    next_cycle();
    for (int i = 0; i < N_REQ; i++) set_word(i, DW'(i));
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      check("fair_ready", 32'(req_ready), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 2) begin
        check("fair_rsp_valid", 32'(rsp_valid), 32'd1);
        check("fair_rsp_id", 32'(rsp_id), 32'((c - 2) % 4));
        check("fair_rsp_data", 32'(rsp_data), 32'(4'hF - 4'((c - 2) % 4)));
      end
      $display("fair cycle %0d: ready=%b rsp_valid=%0d id=%0d data=%0h", c, req_ready, rsp_valid, rsp_id, rsp_data);
      next_cycle();
    end
    #1;
    check("fair_drained", 32'(rsp_valid), 32'd0);

    // Backpressure with both stages full (pointer currently at 3)
    rsp_ready = 1'b0;
    set_word(0, 4'h6);
    set_word(1, 4'h9);
    set_word(2, 4'h3);
    req_valid = 4'b0001;
    #1;
    check("bp_grant0", 32'(req_ready), 32'b0001);
    next_cycle();
    req_valid = 4'b0010;
    #1;
    check("bp_grant1", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = 4'b0100;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready_blocked", 32'(req_ready), 32'd0);
      check("bp_rsp_data", 32'(rsp_data), 32'h9);
      check("bp_rsp_id", 32'(rsp_id), 32'd0);
      check("bp_act_in", 32'(act_in), 32'h9);
      $display("backpressure cycle %0d: ready=%b rsp_data=%0h rsp_id=%0d", c, req_ready, rsp_data, rsp_id);
      next_cycle();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_grant", 32'(req_ready), 32'b0100);
    check("bp_release_valid", 32'(rsp_valid), 32'd1);
    next_cycle();
    req_valid = '0;
    #1;
    check("bp_r1_data", 32'(rsp_data), 32'h6);
    check("bp_r1_id", 32'(rsp_id), 32'd1);
    check("bp_r1_act_in", 32'(act_in), 32'h3);
    next_cycle();
    #1;
    check("bp_r2_data", 32'(rsp_data), 32'hC);
    check("bp_r2_id", 32'(rsp_id), 32'd2);
    next_cycle();
    #1;
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Pointer hold across idle cycles
    req_valid = 4'b0010;
    #1;
    check("ptr_grant1", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = '0;
    repeat (3) next_cycle();
    req_valid = 4'b0101;
    #1;
    check("ptr_first_2", 32'(req_ready), 32'b0100);
    next_cycle();
    req_valid = 4'b0001;
    #1;
    check("ptr_then_0", 32'(req_ready), 32'b0001);
    $display("pointer hold: second grant ready=%b", req_ready);
    next_cycle();
    req_valid = '0;
    repeat (3) next_cycle();

    // Reset mid-flight with both stages occupied
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("mid_grant0", 32'(req_ready), 32'b0001);
    next_cycle();
    req_valid = 4'b0010;
    #1;
    check("mid_grant1", 32'(req_ready), 32'b0010);
    next_cycle();
    req_valid = '0;
    #1;
    check("mid_full_busy", 32'(busy), 32'd1);
    check("mid_full_rsp_valid", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    rsp_ready = 1'b1;
    req_valid = 4'b1001;
    #1;
    check("mid_after_first0", 32'(req_ready), 32'b0001);
    next_cycle();
    req_valid = 4'b1000;
    #1;
    check("mid_after_then3", 32'(req_ready), 32'b1000);
    next_cycle();
    req_valid = '0;
    next_cycle();
    #1;
    check("mid_after_rsp_id", 32'(rsp_id), 32'd3);
    $display("reset mid-flight: resumed grants checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
